piso_tx: RTL and testbench

//  Parallel-in serial-out transmitter; the transmit end of the 1-bit serial link whose receive end is the SIPO shifter.

---
 rtl/piso_pkg.sv | 19 +
 rtl/piso_bit_counter.sv | 27 ++
 rtl/piso_tx.sv | 119 +++++++++++
 tb/tb_piso_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx serial transmitter: FSM state encoding
// and the counter-width helper.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) w++;
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: synchronous clear/load-to-zero, count enable, and a
// terminal-count flag when the count reaches WIDTH-1.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = clog2_min1(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and frame markers.
// Optional even-parity trailer bit enabled by defining PARITY_EN.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int unsigned CW = clog2_min1(WIDTH);

    state_t           state, state_n;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    count;
    logic             tc;
    logic             accept;
    logic             cnt_load;
    logic             cnt_en;
    logic             head;

    assign head   = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    assign accept = load_valid && load_ready;
    // Counter holds at zero outside SHIFT and wraps to zero on the last data bit.
    assign cnt_load = accept || (state != ST_SHIFT) || tc;
    assign cnt_en   = (state == ST_SHIFT) && !tc;

    piso_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .en    (cnt_en),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            sr    <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                sr <= din;
            end else if (state == ST_SHIFT) begin
                sr <= MSB_FIRST ? (sr << 1) : (sr >> 1);
            end
        end
    end

`ifdef PARITY_EN
    logic par;

    always_ff @(posedge clk) begin
        if (reset) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^din;
        end
    end
`endif

    always_comb begin
        state_n     = state;
        load_ready  = 1'b0;
        sout        = IDLE_LEVEL;
        sout_valid  = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        busy        = 1'b0;
        unique case (state)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) state_n = ST_SHIFT;
            end
            ST_SHIFT: begin
                sout        = head;
                sout_valid  = 1'b1;
                busy        = 1'b1;
                frame_start = (count == '0);
                if (tc) begin
`ifdef PARITY_EN
                    state_n = ST_PARITY;
`else
                    frame_end  = 1'b1;
                    load_ready = 1'b1;
                    state_n    = load_valid ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
`ifdef PARITY_EN
            ST_PARITY: begin
                sout       = par;
                sout_valid = 1'b1;
                busy       = 1'b1;
                frame_end  = 1'b1;
                load_ready = 1'b1;
                state_n    = load_valid ? ST_SHIFT : ST_IDLE;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: an MSB-first and an LSB-first instance share
// the same inputs; a per-cycle scoreboard plus table-driven word checks.
module tb_piso_tx;

    localparam int unsigned W = 4;
`ifdef PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int unsigned FL = W + (PAR ? 1 : 0);
    localparam logic IDLE = 1'b0;

    typedef struct packed {
        logic b;
        logic fs;
        logic fe;
    } exp_t;

    typedef struct {
        logic [3:0] din;
        int         gap;
        logic [3:0] seq_msb;
        logic [3:0] seq_lsb;
        logic       par;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] din = 4'hF;
    logic         load_valid = 1'b1;

    logic lr_a, so_a, sv_a, fs_a, fe_a, bz_a;
    logic lr_b, so_b, sv_b, fs_b, fe_b, bz_b;

    int errors = 0;
    int checks = 0;

    exp_t qa[$];
    exp_t qb[$];
    logic [15:0] coll_a = '0, coll_b = '0;
    logic        par_a = 1'b0, par_b = 1'b0;
    int          fs_cnt = 0, fe_cnt = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(IDLE)) dut_a (
        .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(lr_a), .sout(so_a), .sout_valid(sv_a),
        .frame_start(fs_a), .frame_end(fe_a), .busy(bz_a)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(IDLE)) dut_b (
        .clk(clk), .reset(reset), .din(din), .load_valid(load_valid),
        .load_ready(lr_b), .sout(so_b), .sout_valid(sv_b),
        .frame_start(fs_b), .frame_end(fe_b), .busy(bz_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_frame(input int id, input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < int'(W); i++) begin
            e.b  = (id == 0) ? w[W-1-i] : w[i];
            e.fs = (i == 0);
            e.fe = (i == int'(W) - 1) && !PAR;
            if (id == 0) qa.push_back(e); else qb.push_back(e);
        end
        if (PAR) begin
            e.b  = ^w;
            e.fs = 1'b0;
            e.fe = 1'b1;
            if (id == 0) qa.push_back(e); else qb.push_back(e);
        end
    endfunction

    // One cycle of the scoreboard: compare this cycle's outputs, then decide
    // from the model alone whether a word is accepted at the coming edge.
    task automatic mon(input int id, input logic v, input logic s, input logic f0,
                       input logic f1, input logic bz, input logic rdy);
        exp_t       e;
        logic       have;
        logic       er;
        logic [5:0] ev;
        have = (id == 0) ? (qa.size() > 0) : (qb.size() > 0);
        e = '0;
        if (have) begin
            if (id == 0) e = qa.pop_front(); else e = qb.pop_front();
        end
        er = have ? e.fe : 1'b1;
        ev = have ? {1'b1, e.b, e.fs, e.fe, 1'b1, er} : {1'b0, IDLE, 1'b0, 1'b0, 1'b0, 1'b1};
        chk((id == 0) ? "cycle_msb" : "cycle_lsb", {26'd0, v, s, f0, f1, bz, rdy}, {26'd0, ev});
        if (reset) begin
            if (id == 0) qa.delete(); else qb.delete();
        end else if (load_valid && er) begin
            push_frame(id, din);
        end
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            mon(0, sv_a, so_a, fs_a, fe_a, bz_a, lr_a);
            mon(1, sv_b, so_b, fs_b, fe_b, bz_b, lr_b);
            if (sv_a && !(PAR && fe_a)) coll_a = {coll_a[14:0], so_a};
            if (sv_b && !(PAR && fe_b)) coll_b = {coll_b[14:0], so_b};
            if (sv_a && PAR && fe_a) par_a = so_a;
            if (sv_b && PAR && fe_b) par_b = so_b;
            if (fs_a) fs_cnt++;
            if (fe_a) fe_cnt++;
        end
    end

    task automatic send(input logic [W-1:0] w, input int gap);
        din = w;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (FL) @(posedge clk);
        #1;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    vec_t tbl[7];
    int   fs0, fe0;

    initial begin
        tbl[0] = '{din: 4'b1011, gap: 0, seq_msb: 4'b1011, seq_lsb: 4'b1101, par: 1'b1};
        tbl[1] = '{din: 4'b1001, gap: 1, seq_msb: 4'b1001, seq_lsb: 4'b1001, par: 1'b0};
        tbl[2] = '{din: 4'b0000, gap: 2, seq_msb: 4'b0000, seq_lsb: 4'b0000, par: 1'b0};
        tbl[3] = '{din: 4'b1111, gap: 0, seq_msb: 4'b1111, seq_lsb: 4'b1111, par: 1'b0};
        tbl[4] = '{din: 4'b0110, gap: 1, seq_msb: 4'b0110, seq_lsb: 4'b0110, par: 1'b0};
        tbl[5] = '{din: 4'b1100, gap: 0, seq_msb: 4'b1100, seq_lsb: 4'b0011, par: 1'b0};
        tbl[6] = '{din: 4'b0001, gap: 2, seq_msb: 4'b0001, seq_lsb: 4'b1000, par: 1'b1};

        // Reset held two cycles with load_valid high: nothing accepted.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, lr_a}, 32'd1);
        chk("reset_valid", {31'd0, sv_a}, 32'd0);
        chk("reset_busy", {31'd0, bz_a}, 32'd0);
        chk("reset_sout", {31'd0, so_a}, {31'd0, IDLE});
        reset = 1'b0;
        load_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", {31'd0, sv_a | sv_b}, 32'd0);

        // Single word.
        send(4'b1011, 1);
        chk("single_msb", {28'd0, coll_a[3:0]}, 32'h0B);
        chk("single_lsb", {28'd0, coll_b[3:0]}, 32'h0D);

        // Back-to-back words with load_valid held.
        fs0 = fs_cnt;
        fe0 = fe_cnt;
        din = 4'hA;
        load_valid = 1'b1;
        @(posedge clk); #1;
        din = 4'h5;
        repeat (FL) @(posedge clk);
        #1;
        load_valid = 1'b0;
        repeat (FL) @(posedge clk);
        #1;
        chk("b2b_msb", {24'd0, coll_a[7:0]}, 32'hA5);
        chk("b2b_lsb", {24'd0, coll_b[7:0]}, 32'h5A);
        chk("b2b_fs_count", fs_cnt - fs0, 32'd2);
        chk("b2b_fe_count", fe_cnt - fe0, 32'd2);
        @(posedge clk); #1;

        // Reset after two bits of 4'hF.
        fe0 = fe_cnt;
        din = 4'hF;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_valid", {31'd0, sv_a}, 32'd0);
        chk("abort_ready", {31'd0, lr_a}, 32'd1);
        chk("abort_busy", {31'd0, bz_a}, 32'd0);
        chk("abort_no_fe", fe_cnt - fe0, 32'd0);
        send(4'h6, 1);
        chk("after_abort_msb", {28'd0, coll_a[3:0]}, 32'h6);
        chk("after_abort_lsb", {28'd0, coll_b[3:0]}, 32'h6);

        // din toggled while the frame is in flight.
        din = 4'b1011;
        load_valid = 1'b1;
        @(posedge clk); #1;
        load_valid = 1'b0;
        for (int i = 0; i < int'(FL); i++) begin
            din = ~din;
            @(posedge clk); #1;
        end
        chk("toggle_msb", {28'd0, coll_a[3:0]}, 32'h0B);
        chk("toggle_lsb", {28'd0, coll_b[3:0]}, 32'h0D);

        // Table-driven words with varying idle gaps.
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].din, tbl[i].gap);
            chk("tbl_msb", {28'd0, coll_a[3:0]}, {28'd0, tbl[i].seq_msb});
            chk("tbl_lsb", {28'd0, coll_b[3:0]}, {28'd0, tbl[i].seq_lsb});
`ifdef PARITY_EN
            chk("tbl_par_msb", {31'd0, par_a}, {31'd0, tbl[i].par});
            chk("tbl_par_lsb", {31'd0, par_b}, {31'd0, tbl[i].par});
`endif
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained_msb", qa.size(), 32'd0);
        chk("queue_drained_lsb", qb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
